// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and helpers for the 4x4 keypad row-scan controller.
//            Provides the matrix dimensions, the scanner state encoding and
//            the row/column -> key index mapping.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Key index = row*4 + col; with 2-bit fields this is a plain concatenation.
   function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : dwell_counter
// Purpose  : Up-counter shared by the scanner for row dwell and debounce
//            counting. done flags the enabled cycle on which the count reaches
//            the programmed last value, i.e. the N-th counted cycle.
// Ports    : clk, reset (sync, active-high), clear (sync clear, wins over en),
//            en (count this cycle), last (terminal count = N-1), done.
// Revision : 1.0 - initial release
// ============================================================================
module dwell_counter #(
   parameter  int MAX = 8,
   localparam int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic         done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = en && (count_q == last);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Row-scan controller for a 4x4 active-low matrix keypad. Drives
//            one row low at a time, samples the synchronized columns at the
//            end of each row dwell, debounces press and release, and emits a
//            one-cycle key_valid strobe with the key index.
// Ports    : clk, reset (sync, active-high)
//            col_sync  [3:0] in  synchronized columns, 0 = pressed
//            row_n     [3:0] out row drive, exactly one bit low
//            key_valid       out one-cycle strobe on accepted press
//            key_code  [3:0] out row*4+col, held between strobes
//            key_held        out high from strobe until release debounced
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COLS-1:0] col_sync,
   output logic [NUM_ROWS-1:0] row_n,
   output logic                key_valid,
   output logic [3:0]          key_code,
   output logic                key_held
);

   localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   scan_state_t         state_q, state_d;
   logic [1:0]          row_idx_q, row_idx_d;
   logic [1:0]          col_idx_q, col_idx_d;
   logic [NUM_ROWS-1:0] row_n_q, row_n_d;
   logic [3:0]          key_code_q, key_code_d;
   logic                key_valid_q, key_valid_d;
   logic                key_held_q, key_held_d;

   logic                cnt_clear;
   logic                cnt_en;
   logic                cnt_done;
   logic [CNT_W-1:0]    cnt_last;

   logic                any_low;
   logic [1:0]          first_low;
   logic                sel_col;

   dwell_counter #(.MAX(CNT_MAX)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .en    (cnt_en),
      .last  (cnt_last),
      .done  (cnt_done)
   );

   // Lowest-index low column wins: scan downward so the last hit is the lowest.
   always_comb begin
      first_low = 2'd0;
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
         if (!col_sync[c]) begin
            first_low = 2'(c);
         end
      end
   end

   assign any_low = (col_sync != '1);
   assign sel_col = col_sync[col_idx_q];

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      col_idx_d   = col_idx_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      cnt_en      = 1'b0;
      cnt_clear   = 1'b0;
      cnt_last    = SCAN_LAST;

      case (state_q)
         SCAN: begin
            cnt_en = 1'b1;
            if (cnt_done) begin
               cnt_clear = 1'b1;
               if (any_low) begin
                  col_idx_d = first_low;
                  state_d   = DEBOUNCE;
               end else begin
                  row_idx_d = row_idx_q + 1'b1;
               end
            end
         end
         DEBOUNCE: begin
            cnt_last = DEB_LAST;
            cnt_en   = !sel_col;
            if (sel_col) begin
               // Bounce: give up on this key and move on to the next row.
               cnt_clear = 1'b1;
               row_idx_d = row_idx_q + 1'b1;
               state_d   = SCAN;
            end else if (cnt_done) begin
               cnt_clear   = 1'b1;
               key_valid_d = 1'b1;
               key_code_d  = key_index(row_idx_q, col_idx_q);
               key_held_d  = 1'b1;
               state_d     = HELD;
            end
         end
         HELD: begin
            if (sel_col) begin
               cnt_clear = 1'b1;
               state_d   = RELEASE;
            end
         end
         RELEASE: begin
            cnt_last = DEB_LAST;
            cnt_en   = sel_col;
            if (!sel_col) begin
               cnt_clear = 1'b1;
               state_d   = HELD;
            end else if (cnt_done) begin
               cnt_clear  = 1'b1;
               key_held_d = 1'b0;
               row_idx_d  = row_idx_q + 1'b1;
               state_d    = SCAN;
            end
         end
         default: begin
            cnt_clear = 1'b1;
            state_d   = SCAN;
         end
      endcase

      row_n_d = ~(NUM_ROWS'(1) << row_idx_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         row_idx_q   <= 2'd0;
         col_idx_q   <= 2'd0;
         row_n_q     <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
         row_n_q     <= row_n_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign row_n     = row_n_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;

endmodule
`default_nettype wire
